// File: rtl/idli_boot_load.sv
// Boot loader: streams image bytes from a byte source into an SQI SRAM
// (write opcode, 24-bit address, data nibbles) and then releases the core.
module idli_boot_load #(
    parameter int unsigned IMG_BYTES = 256,
    parameter logic [23:0] BASE_ADDR = 24'h000000
) (
    input  logic       i_boot_gck,
    input  logic       i_boot_rst_n,
    input  logic [7:0] i_boot_data,
    input  logic       i_boot_data_vld,
    output logic       o_boot_data_acp,
    output logic       o_boot_sck,
    output logic       o_boot_cs,
    output logic [3:0] o_boot_sio,
    output logic       o_boot_sio_oe,
    output logic       o_boot_done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        ADDR = 3'd2,
        WAIT = 3'd3,
        DHI  = 3'd4,
        DLO  = 3'd5,
        END  = 3'd6,
        DONE = 3'd7
    } state_t;

    localparam logic [16:0] IMG_CNT = 17'(IMG_BYTES);

    state_t      state_q;
    logic        phase_q;
    logic [2:0]  nib_q;
    logic [3:0]  lo_q;
    logic [16:0] cnt_q;
    logic [16:0] cnt_d;
    logic        sck_q;
    logic        cs_q;
    logic [3:0]  sio_q;
    logic        oe_q;
    logic        done_q;
    logic        acp_s;

    // Write opcode 8'h02, high nibble first.
    function automatic logic [3:0] cmd_nibble(input logic [2:0] idx);
        logic [3:0] nib;
        case (idx)
            3'd0:    nib = 4'h0;
            3'd1:    nib = 4'h2;
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

    // Start address, most significant nibble first.
    function automatic logic [3:0] addr_nibble(input logic [2:0] idx);
        logic [3:0] nib;
        case (idx)
            3'd0:    nib = BASE_ADDR[23:20];
            3'd1:    nib = BASE_ADDR[19:16];
            3'd2:    nib = BASE_ADDR[15:12];
            3'd3:    nib = BASE_ADDR[11:8];
            3'd4:    nib = BASE_ADDR[7:4];
            3'd5:    nib = BASE_ADDR[3:0];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

    // Byte handshake is only open while parked in WAIT.
    always_comb begin
        acp_s = 1'b0;
        cnt_d = cnt_q + 17'd1;
        acp_s = (state_q == WAIT) && i_boot_data_vld;
    end

    // Loader sequencer; every SQI pin is a register updated with the state.
    always_ff @(posedge i_boot_gck or negedge i_boot_rst_n) begin
        if (!i_boot_rst_n) begin
            state_q <= IDLE;
            phase_q <= 1'b0;
            nib_q   <= 3'd0;
            lo_q    <= 4'h0;
            cnt_q   <= 17'd0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            sio_q   <= 4'h0;
            oe_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= CMD;
                    phase_q <= 1'b0;
                    nib_q   <= 3'd0;
                    cnt_q   <= 17'd0;
                    cs_q    <= 1'b0;
                    oe_q    <= 1'b1;
                    sck_q   <= 1'b0;
                    sio_q   <= cmd_nibble(3'd0);
                end
                CMD: begin
                    if (!phase_q) begin
                        sck_q   <= 1'b1;
                        phase_q <= 1'b1;
                    end else begin
                        sck_q   <= 1'b0;
                        phase_q <= 1'b0;
                        if (nib_q == 3'd1) begin
                            state_q <= ADDR;
                            nib_q   <= 3'd0;
                            sio_q   <= addr_nibble(3'd0);
                        end else begin
                            nib_q <= nib_q + 3'd1;
                            sio_q <= cmd_nibble(nib_q + 3'd1);
                        end
                    end
                end
                ADDR: begin
                    if (!phase_q) begin
                        sck_q   <= 1'b1;
                        phase_q <= 1'b1;
                    end else begin
                        sck_q   <= 1'b0;
                        phase_q <= 1'b0;
                        if (nib_q == 3'd5) begin
                            state_q <= WAIT;
                            nib_q   <= 3'd0;
                        end else begin
                            nib_q <= nib_q + 3'd1;
                            sio_q <= addr_nibble(nib_q + 3'd1);
                        end
                    end
                end
                WAIT: begin
                    // SCK simply stalls low while the source has nothing for us.
                    if (acp_s) begin
                        state_q <= DHI;
                        phase_q <= 1'b0;
                        lo_q    <= i_boot_data[3:0];
                        sio_q   <= i_boot_data[7:4];
                        sck_q   <= 1'b0;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                DHI: begin
                    if (!phase_q) begin
                        sck_q   <= 1'b1;
                        phase_q <= 1'b1;
                    end else begin
                        state_q <= DLO;
                        sck_q   <= 1'b0;
                        phase_q <= 1'b0;
                        sio_q   <= lo_q;
                    end
                end
                DLO: begin
                    if (!phase_q) begin
                        sck_q   <= 1'b1;
                        phase_q <= 1'b1;
                    end else begin
                        sck_q   <= 1'b0;
                        phase_q <= 1'b0;
                        cnt_q   <= cnt_d;
                        if (cnt_d < IMG_CNT) begin
                            state_q <= WAIT;
                        end else begin
                            state_q <= END;
                            cs_q    <= 1'b1;
                            oe_q    <= 1'b0;
                            sio_q   <= 4'h0;
                        end
                    end
                end
                END: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    cs_q    <= 1'b1;
                    sck_q   <= 1'b0;
                    oe_q    <= 1'b0;
                end
                DONE: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                    cs_q    <= 1'b1;
                    sck_q   <= 1'b0;
                    oe_q    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    cs_q    <= 1'b1;
                    sck_q   <= 1'b0;
                    oe_q    <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_boot_data_acp = acp_s;
    assign o_boot_sck      = sck_q;
    assign o_boot_cs       = cs_q;
    assign o_boot_sio      = sio_q;
    assign o_boot_sio_oe   = oe_q;
    assign o_boot_done     = done_q;

endmodule

// File: tb/tb_idli_boot_load.sv
// Bench for idli_boot_load: two instances (4-byte image at 0x012345, 1-byte
// image at 0x000000) checked against a nibble scoreboard and cycle timing.
module tb_idli_boot_load;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] d4 = 8'h00, d1 = 8'h00;
    logic       v4 = 1'b0,  v1 = 1'b0;
    logic       acp4, sck4, cs4, oe4, done4;
    logic       acp1, sck1, cs1, oe1, done1;
    logic [3:0] sio4, sio1;

    always #5 clk = ~clk;

    idli_boot_load #(.IMG_BYTES(4), .BASE_ADDR(24'h012345)) u_dut4 (
        .i_boot_gck(clk), .i_boot_rst_n(rst_n),
        .i_boot_data(d4), .i_boot_data_vld(v4), .o_boot_data_acp(acp4),
        .o_boot_sck(sck4), .o_boot_cs(cs4), .o_boot_sio(sio4),
        .o_boot_sio_oe(oe4), .o_boot_done(done4)
    );

    idli_boot_load #(.IMG_BYTES(1), .BASE_ADDR(24'h000000)) u_dut1 (
        .i_boot_gck(clk), .i_boot_rst_n(rst_n),
        .i_boot_data(d1), .i_boot_data_vld(v1), .o_boot_data_acp(acp1),
        .o_boot_sck(sck1), .o_boot_cs(cs1), .o_boot_sio(sio1),
        .o_boot_sio_oe(oe1), .o_boot_done(done1)
    );

    typedef struct {
        logic [7:0] data;
        int         gap;
        logic [3:0] hi;
        logic [3:0] lo;
    } vec_t;

    vec_t       tbl [8];
    logic [3:0] hdr4 [8];
    logic [3:0] hdr1 [8];
    logic [3:0] q4 [$];
    logic [3:0] q1 [$];
    logic       sck4_p = 1'b0, sck1_p = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0b want=%0b", name, cyc, act, exp);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs just after the edge, sample on the falling edge,
    // and score each nibble the SRAM would latch on an SCK rise.
    task automatic step(input logic a_v4, input logic [7:0] a_d4,
                        input logic a_v1, input logic [7:0] a_d1);
        @(posedge clk);
        #1;
        cyc++;
        v4 = a_v4; d4 = a_d4; v1 = a_v1; d1 = a_d1;
        @(negedge clk);
        if (!cs4 && sck4 && !sck4_p) begin
            if (q4.size() == 0) chki("nib4_extra", 32'(sio4), -1);
            else chk4("nib4", sio4, q4.pop_front());
        end
        if (!cs1 && sck1 && !sck1_p) begin
            if (q1.size() == 0) chki("nib1_extra", 32'(sio1), -1);
            else chk4("nib1", sio1, q1.pop_front());
        end
        sck4_p = sck4;
        sck1_p = sck1;
    endtask

    task automatic chk_reset_state();
        chk1("rst_cs4", cs4, 1'b1);     chk1("rst_cs1", cs1, 1'b1);
        chk1("rst_sck4", sck4, 1'b0);   chk1("rst_sck1", sck1, 1'b0);
        chk4("rst_sio4", sio4, 4'h0);   chk4("rst_sio1", sio1, 4'h0);
        chk1("rst_oe4", oe4, 1'b0);     chk1("rst_oe1", oe1, 1'b0);
        chk1("rst_done4", done4, 1'b0); chk1("rst_done1", done1, 1'b0);
        chk1("rst_acp4", acp4, 1'b0);   chk1("rst_acp1", acp1, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v4 = 1'b1; v1 = 1'b1;
        #1;
        chk_reset_state();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state();
        q4.delete();
        q1.delete();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        cyc    = 0;
        sck4_p = 1'b0;
        sck1_p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            q4.push_back(hdr4[i]);
            q1.push_back(hdr1[i]);
        end
    endtask

    // Both images with valid held high, then keep vld high well past done.
    task automatic run_stream();
        int i4;
        i4 = 0;
        for (int n = 0; n < 50; n++) begin
            step(1'b1, tbl[(i4 < 4) ? i4 : 3].data, 1'b1, 8'hA5);
            chk1("acp4", acp4, (cyc == 17) || (cyc == 22) || (cyc == 27) || (cyc == 32));
            chk1("acp1", acp1, cyc == 17);
            chk1("done4", done4, cyc >= 38);
            chk1("done1", done1, cyc >= 23);
            chk1("cs4", cs4, cyc >= 37);
            chk1("cs1", cs1, cyc >= 22);
            chk1("oe4", oe4, cyc < 37);
            chk1("oe1", oe1, cyc < 22);
            if (acp4 && i4 < 4) begin
                q4.push_back(tbl[i4].hi);
                q4.push_back(tbl[i4].lo);
                i4++;
            end
            if (acp1) begin
                q1.push_back(4'hA);
                q1.push_back(4'h5);
            end
        end
        chki("stream_bytes4", i4, 4);
        chki("stream_q4_left", q4.size(), 0);
        chki("stream_q1_left", q1.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int  got;
        int  i4;

        tbl[0] = '{8'h01, 0,  4'h0, 4'h1};
        tbl[1] = '{8'h02, 0,  4'h0, 4'h2};
        tbl[2] = '{8'h03, 0,  4'h0, 4'h3};
        tbl[3] = '{8'h04, 0,  4'h0, 4'h4};
        tbl[4] = '{8'h5A, 0,  4'h5, 4'hA};
        tbl[5] = '{8'hC3, 10, 4'hC, 4'h3};
        tbl[6] = '{8'h7E, 2,  4'h7, 4'hE};
        tbl[7] = '{8'hFF, 0,  4'hF, 4'hF};
        hdr4 = '{4'h0, 4'h2, 4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        hdr1 = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

        #2;
        do_reset();
        run_stream();

        // Source stalls inside WAIT, plus valid rising while busy in DHI/DLO.
        do_reset();
        got = 0;
        for (int n = 0; n < 30 && got == 0; n++) begin
            step(1'b1, tbl[4].data, 1'b0, 8'h00);
            if (acp4) got = 1;
        end
        chki("first_acp_seen", got, 1);
        chki("first_acp_cyc", cyc, 17);
        q4.push_back(tbl[4].hi);
        q4.push_back(tbl[4].lo);
        for (int k = 5; k < 8; k++) begin
            for (int j = 0; j < 4; j++) begin
                step(tbl[k].gap == 0, tbl[k].data, 1'b0, 8'h00);
                chk1("acp_busy", acp4, 1'b0);
            end
            for (int j = 0; j < tbl[k].gap; j++) begin
                step(1'b0, tbl[k].data, 1'b0, 8'h00);
                chk1("stall_cs", cs4, 1'b0);
                chk1("stall_sck", sck4, 1'b0);
                chk1("stall_acp", acp4, 1'b0);
                chk4("stall_sio", sio4, tbl[k-1].lo);
            end
            step(1'b1, tbl[k].data, 1'b0, 8'h00);
            chk1("acp_resume", acp4, 1'b1);
            q4.push_back(tbl[k].hi);
            q4.push_back(tbl[k].lo);
        end
        for (int j = 0; j < 8; j++) step(1'b0, 8'h00, 1'b0, 8'h00);
        chk1("gap_done4", done4, 1'b1);
        chk1("gap_cs4", cs4, 1'b1);
        chk1("gap_done1", done1, 1'b0);
        chk1("gap_cs1", cs1, 1'b0);
        chki("gap_q4_left", q4.size(), 0);
        chki("gap_q1_left", q1.size(), 0);

        // Reset lands in DLO phase 0 of the second byte, then a full replay.
        do_reset();
        i4 = 0;
        for (int n = 0; n < 25; n++) begin
            step(1'b1, tbl[i4].data, 1'b0, 8'h00);
            if (acp4 && i4 < 2) begin
                q4.push_back(tbl[i4].hi);
                q4.push_back(tbl[i4].lo);
                i4++;
            end
        end
        chki("abort_cyc", cyc, 25);
        chki("abort_bytes", i4, 2);
        chk1("abort_sck_pre", sck4, 1'b0);
        chk4("abort_sio_pre", sio4, tbl[1].lo);
        chki("abort_q4_pending", q4.size(), 1);
        rst_n = 1'b0;
        #1;
        chk1("abort_cs", cs4, 1'b1);
        chk1("abort_oe", oe4, 1'b0);
        chk1("abort_sck", sck4, 1'b0);
        chk1("abort_done", done4, 1'b0);
        do_reset();
        run_stream();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
